// File: rtl/ntt_seq_pkg.sv
// Shared types and helpers for the NTT stage sequencer.
// Stage offsets, bit reversal and the modulus of the pipeline.
package ntt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam int MODULUS = 7681;

    function automatic int stage_offset(
        input int s,
        input int n,
        input int pipe
    );
        return (n - (n >> s)) + s * pipe;
    endfunction

    function automatic logic [31:0] bitrev(
        input logic [31:0] x,
        input int          log2n
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < log2n; i++) begin
            r[i] = x[log2n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_stage_ctrl.sv
// Per-stage decode of the shared frame counter into the
// fill/butterfly select and the twiddle exponent.
module ntt_stage_ctrl
    import ntt_seq_pkg::*;
#(
    parameter int S          = 0,
    parameter int N          = 16,
    parameter int LOG2N      = $clog2(N),
    parameter int STAGE_PIPE = 0
) (
    input  logic [LOG2N-1:0] cnt,
    output logic             bf,
    output logic [LOG2N-2:0] tw_exp
);

    localparam int OFF_INT = stage_offset(S, N, STAGE_PIPE) % N;
    localparam logic [LOG2N-1:0] OFFSET = LOG2N'(OFF_INT);
    localparam logic [LOG2N-1:0] TW_MASK = LOG2N'((N >> (S + 1)) - 1);
    localparam logic [LOG2N-1:0] BF_MASK = LOG2N'(1) << (LOG2N - 1 - S);

    logic [LOG2N-1:0] c;

    assign c      = cnt - OFFSET;
    assign bf     = |(c & BF_MASK);
    // Exponent never exceeds N/2-1, so the top counter bit is not needed.
    assign tw_exp = (LOG2N-1)'((c & TW_MASK) << S);

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Frame-counter controller for the radix-2 SDF NTT chain.
// NTT_SEQ_BITREV_EN selects bit-reversed output indexing.
module ntt_stage_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int N          = 16,
    parameter int LOG2N      = $clog2(N),
    parameter int STAGE_PIPE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         stage_en,
    output logic [LOG2N-1:0]             stage_bf,
    output logic [LOG2N*(LOG2N-1)-1:0]   twiddle_exp,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [LOG2N-1:0]             out_index,
    output logic                         busy
);

    localparam int TL = N - 1 + LOG2N * STAGE_PIPE;
    localparam logic [LOG2N-1:0] TL_MOD   = LOG2N'(TL % N);
    localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [LOG2N-1:0] cnt;
    logic [LOG2N-1:0] cnt_inc;
    logic [LOG2N-1:0] out_cnt;
    logic [TL-1:0]    tracker;
    logic             advance;
    logic             load;

    assign cnt_inc = cnt + 1'b1;
    assign load    = (state != FLUSH) & in_valid;

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                advance = in_valid;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                advance = in_valid;
                if (cnt == '0 && !in_valid) state_next = FLUSH;
            end
            FLUSH: begin
                in_ready = 1'b0;
                advance  = 1'b1;
                if (tracker == '0 && cnt_inc == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Held reset must not strobe the stages even with in_valid high.
        advance = advance & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tracker <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                cnt     <= cnt_inc;
                tracker <= {tracker[TL-2:0], load};
            end
        end
    end

    assign stage_en  = advance;
    assign out_valid = advance & tracker[TL-1];
    assign out_cnt   = cnt - TL_MOD;
    assign out_last  = out_valid & (out_cnt == LAST_CNT);
    assign busy      = (state != IDLE);

`ifdef NTT_SEQ_BITREV_EN
    assign out_index = out_valid ? LOG2N'(bitrev(32'(out_cnt), LOG2N)) : '0;
`else
    assign out_index = out_valid ? out_cnt : '0;
`endif

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        ntt_stage_ctrl #(
            .S          (s),
            .N          (N),
            .LOG2N      (LOG2N),
            .STAGE_PIPE (STAGE_PIPE)
        ) u_ctrl (
            .cnt    (cnt),
            .bf     (stage_bf[s]),
            .tw_exp (twiddle_exp[s*(LOG2N-1) +: LOG2N-1])
        );
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer with an output scoreboard.
// Honors NTT_SEQ_BITREV_EN for the expected output index.
module tb_ntt_stage_sequencer;

    localparam int N     = 16;
    localparam int LOG2N = 4;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic                       stage_en;
    logic [LOG2N-1:0]           stage_bf;
    logic [LOG2N*(LOG2N-1)-1:0] twiddle_exp;
    logic                       out_valid;
    logic                       out_last;
    logic [LOG2N-1:0]           out_index;
    logic                       busy;

    int total = 0;
    int bad   = 0;
    int acc   = 0;
    int sb[$];

    ntt_stage_sequencer #(
        .N          (N),
        .LOG2N      (LOG2N),
        .STAGE_PIPE (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stage_en    (stage_en),
        .stage_bf    (stage_bf),
        .twiddle_exp (twiddle_exp),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_index   (out_index),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (x[i]) r = r | (1 << (LOG2N - 1 - i));
        end
        return r;
    endfunction

    function automatic int exp_idx(input int e);
`ifdef NTT_SEQ_BITREV_EN
        return brev(e);
`else
        return e;
`endif
    endfunction

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic cyc(input logic v);
        int e;
        @(negedge clk);
        in_valid = v;
        #1;
        if (out_valid) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_last", 32'(out_last), 32'(e == N - 1));
                chk("sb_index", 32'(out_index), 32'(exp_idx(e)));
            end
        end
        if (v && in_ready) begin
            sb.push_back(acc % N);
            acc++;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_en", 32'(stage_en), 0);
        chk("rst_bf", 32'(stage_bf), 0);
        chk("rst_tw", 32'(twiddle_exp), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_idx", 32'(out_index), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // One 16-sample frame with an optional d-cycle stall at cnt=5.
    task automatic run_frame(input int d);
        logic v;
        int   k;
        logic fl;
        for (int c = 0; c <= 40 + d; c++) begin
            v  = (c < 5) || (c >= 5 + d && c < 16 + d);
            fl = (c >= 17 + d) && (c <= 32 + d);
            cyc(v);
            chk("fr_ov", 32'(out_valid),
                32'((c == 15 + d) || (c >= 17 + d && c <= 31 + d)));
            chk("fr_last", 32'(out_last), 32'(c == 31 + d));
            chk("fr_ready", 32'(in_ready), 32'(!fl));
            chk("fr_en", 32'(stage_en), 32'(v || fl));
            chk("fr_busy", 32'(busy), 32'(c >= 1 && c <= 32 + d));
            if (c >= 5 && c < 5 + d) begin
                chk("stall_tw0", 32'(twiddle_exp[2:0]), 5);
                chk("stall_bf0", 32'(stage_bf[0]), 0);
            end else if (c <= 15 + d) begin
                k = (c < 5) ? c : c - d;
                chk("tw_bf0", 32'(stage_bf[0]), 32'(k >= 8));
                chk("tw_exp0", 32'(twiddle_exp[2:0]), 32'(k % 8));
                if (k >= 8) chk("tw_bf1", 32'(stage_bf[1]), 32'(k >= 12));
                if (k >= 12)
                    chk("tw_exp1", 32'(twiddle_exp[5:3]), 32'((k - 12) * 2));
            end
        end
    endtask

    initial begin
        int nov;
        int nlast;
        int nrdy0;

        rst      = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_frame(0);
        run_frame(3);

        nov   = 0;
        nlast = 0;
        nrdy0 = 0;
        for (int c = 0; c <= 90; c++) begin
            cyc(c < 48);
            if (c < 48) chk("b2b_ready", 32'(in_ready), 1);
            if (out_valid) nov++;
            if (out_last) nlast++;
            if (!in_ready) nrdy0++;
        end
        chk("b2b_nvalid", 32'(nov), 48);
        chk("b2b_nlast", 32'(nlast), 3);
        chk("b2b_nflush", 32'(nrdy0), 16);
        chk("b2b_idle", 32'(busy), 0);

        for (int c = 0; c < 10; c++) cyc(1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        sb.delete();
        acc = 0;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b0);
            chk("post_rst_ov", 32'(out_valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end

        run_frame(0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
